// File: rtl/dgio_mbox_if.sv
// dgio_mbox_if: word bus between the dgio PIM bridge (master) and the
// mailbox (slave).
//   write      master->slave  write strobe, one word per high cycle
//   writedata  master->slave  32-bit write data
//   address    master->slave  6-bit word address (reads and writes)
//   readdata   slave->master  registered read data, 1-cycle latency
//   irq        slave->master  registered level interrupt
interface dgio_mbox_if;
  logic        write;
  logic [31:0] writedata;
  logic [5:0]  address;
  logic [31:0] readdata;
  logic        irq;

  modport master (output write, writedata, address, input readdata, irq);
  modport slave  (input write, writedata, address, output readdata, irq);
endinterface

// File: rtl/dgio_mbox.sv
// dgio_mbox: register-mapped mailbox behind the dgio PIM bridge.
// Provides ID, CTRL (irq enable, flush), masked W1C interrupt status,
// a scratch register, a TX FIFO (host -> user stream) and an RX FIFO
// (user stream -> host).
// Ports:
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   bus                 dgio_mbox_if slave: write/writedata/address in,
//                       readdata/irq out
//   tx_data/tx_valid    TX FIFO head word / not empty
//   tx_ready            user pops TX head when tx_valid & tx_ready
//   rx_data/rx_valid    user word offered to the RX FIFO
//   rx_ready            RX FIFO not full
module dgio_mbox #(
  parameter logic [31:0] C_ID      = 32'h4447_0100,
  parameter int          C_FIFO_AW = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  dgio_mbox_if.slave  bus,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int Depth = 2 ** C_FIFO_AW;
  localparam logic [C_FIFO_AW:0] FullCount = {1'b1, {C_FIFO_AW{1'b0}}};
  localparam logic [C_FIFO_AW:0] OneCount  = {{C_FIFO_AW{1'b0}}, 1'b1};

  // FIFO storage; read combinationally so the head is show-ahead.
  logic [31:0] txMem [Depth];
  logic [31:0] rxMem [Depth];

  logic [C_FIFO_AW-1:0] txWrPtr, txRdPtr, rxWrPtr, rxRdPtr;
  logic [C_FIFO_AW:0]   txCount, rxCount;
  logic                 irqEn;
  logic [3:0]           irqStat, irqMask;
  logic [31:0]          scratch;
  logic [31:0]          readdataReg;
  logic                 irqReg;

  // Address decode of write strobes
  logic wrCtrl, wrIrqStat, wrIrqMask, wrTxData, wrRxPop, wrScratch;
  assign wrCtrl    = bus.write && (bus.address == 6'h01);
  assign wrIrqStat = bus.write && (bus.address == 6'h02);
  assign wrIrqMask = bus.write && (bus.address == 6'h03);
  assign wrTxData  = bus.write && (bus.address == 6'h04);
  assign wrRxPop   = bus.write && (bus.address == 6'h06);
  assign wrScratch = bus.write && (bus.address == 6'h08);

  logic txFull, txEmpty, rxFull, rxEmpty;
  assign txFull  = (txCount == FullCount);
  assign txEmpty = (txCount == '0);
  assign rxFull  = (rxCount == FullCount);
  assign rxEmpty = (rxCount == '0);

  // Stream handshakes depend only on registered counts.
  assign tx_valid = !txEmpty;
  assign rx_ready = !rxFull;
  assign tx_data  = txMem[txRdPtr];

  logic flush, txPush, txPop, rxPush, rxPop;
  assign flush  = wrCtrl && bus.writedata[1];
  // Full check uses the pre-pop count: a write into a full FIFO is dropped
  // even if the user pops in the same cycle.
  assign txPush = wrTxData && !txFull && !flush;
  assign txPop  = tx_valid && tx_ready;
  assign rxPush = rx_valid && rx_ready && !flush;
  assign rxPop  = wrRxPop && !rxEmpty;

  // Interrupt set events; a flush cycle raises none of them.
  logic [3:0] setBits, clrBits, irqStatNext;
  assign setBits[0] = rxPush && rxEmpty;
  assign setBits[1] = wrTxData && txFull && !flush;
  assign setBits[2] = wrRxPop && rxEmpty;
  assign setBits[3] = txPop && (txCount == OneCount) && !txPush && !flush;
  assign clrBits    = wrIrqStat ? bus.writedata[3:0] : 4'b0000;
  // Set wins over a same-cycle W1C.
  assign irqStatNext = (irqStat & ~clrBits) | setBits;

  // Read mux from pre-write state; sampled into readdataReg at the edge.
  logic [31:0] rdData;
  always_comb begin
    rdData = '0;
    case (bus.address)
      6'h00: rdData = C_ID;
      6'h01: rdData[0] = irqEn;
      6'h02: rdData[3:0] = irqStat;
      6'h03: rdData[3:0] = irqMask;
      6'h05: rdData = rxEmpty ? 32'h0 : rxMem[rxRdPtr];
      6'h07: begin
        rdData[7:0]  = 8'(txCount);
        rdData[15:8] = 8'(rxCount);
        rdData[16]   = txFull;
        rdData[17]   = txEmpty;
        rdData[18]   = rxFull;
        rdData[19]   = rxEmpty;
      end
      6'h08: rdData = scratch;
      default: rdData = '0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      txWrPtr     <= '0;
      txRdPtr     <= '0;
      txCount     <= '0;
      rxWrPtr     <= '0;
      rxRdPtr     <= '0;
      rxCount     <= '0;
      irqEn       <= 1'b0;
      irqStat     <= '0;
      irqMask     <= '0;
      scratch     <= '0;
      readdataReg <= '0;
      irqReg      <= 1'b0;
    end else begin
      readdataReg <= rdData;
      irqReg      <= irqEn && |(irqStat & irqMask);
      irqStat     <= irqStatNext;
      if (wrCtrl)    irqEn   <= bus.writedata[0];
      if (wrIrqMask) irqMask <= bus.writedata[3:0];
      if (wrScratch) scratch <= bus.writedata;

      if (flush) begin
        txWrPtr <= '0;
        txRdPtr <= '0;
        txCount <= '0;
        rxWrPtr <= '0;
        rxRdPtr <= '0;
        rxCount <= '0;
      end else begin
        if (txPush) txWrPtr <= txWrPtr + 1'b1;
        if (txPop)  txRdPtr <= txRdPtr + 1'b1;
        if (txPush && !txPop)      txCount <= txCount + 1'b1;
        else if (!txPush && txPop) txCount <= txCount - 1'b1;

        if (rxPush) rxWrPtr <= rxWrPtr + 1'b1;
        if (rxPop)  rxRdPtr <= rxRdPtr + 1'b1;
        if (rxPush && !rxPop)      rxCount <= rxCount + 1'b1;
        else if (!rxPush && rxPop) rxCount <= rxCount - 1'b1;
      end
    end
  end

  // Storage needs no reset: pointers and counts define what is valid.
  always_ff @(posedge sys_clk) begin
    if (txPush) txMem[txWrPtr] <= bus.writedata;
    if (rxPush) rxMem[rxWrPtr] <= rx_data;
  end

  assign bus.readdata = readdataReg;
  assign bus.irq      = irqReg;

endmodule

// File: tb/tb_dgio_mbox.sv
// tb_dgio_mbox: table-driven register checks plus hand-written sequences
// for FIFO fill/overflow, interrupts, flush, continuous streaming and reset.
module tb_dgio_mbox;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int checks = 0;
  int errors = 0;

  dgio_mbox_if bus ();

  dgio_mbox dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string       name;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // One bus cycle: drive, cross the rising edge, settle 1 time unit.
  // readdata afterwards reflects this cycle's address.
  task automatic step(input logic w, input logic [5:0] a, input logic [31:0] d);
    bus.write     = w;
    bus.address   = a;
    bus.writedata = d;
    @(posedge sys_clk);
    #1;
    bus.write = 1'b0;
  endtask

  task automatic rd(input string name, input logic [5:0] a, input logic [31:0] exp);
    step(1'b0, a, 32'h0);
    check(name, bus.readdata, exp);
  endtask

  initial begin
    bus.write = 1'b0;
    bus.address = '0;
    bus.writedata = '0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data = '0;

    vecs.push_back(vec_t'{"id",          1'b0, 6'h00, 32'h0,         1'b1, 32'h4447_0100});
    vecs.push_back(vec_t'{"fstat_rst",   1'b0, 6'h07, 32'h0,         1'b1, 32'h000A_0000});
    vecs.push_back(vec_t'{"unmapped",    1'b0, 6'h3F, 32'h0,         1'b1, 32'h0});
    vecs.push_back(vec_t'{"id_wr",       1'b1, 6'h00, 32'h123,       1'b0, 32'h0});
    vecs.push_back(vec_t'{"id_ro",       1'b0, 6'h00, 32'h0,         1'b1, 32'h4447_0100});
    vecs.push_back(vec_t'{"scr_wr",      1'b1, 6'h08, 32'hDEAD_BEEF, 1'b0, 32'h0});
    vecs.push_back(vec_t'{"scr_rd",      1'b0, 6'h08, 32'h0,         1'b1, 32'hDEAD_BEEF});
    vecs.push_back(vec_t'{"scr_rd_old",  1'b1, 6'h08, 32'h5555_5555, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back(vec_t'{"scr_rd_new",  1'b0, 6'h08, 32'h0,         1'b1, 32'h5555_5555});
    vecs.push_back(vec_t'{"mask_wr",     1'b1, 6'h03, 32'hFFFF_FFFF, 1'b0, 32'h0});
    vecs.push_back(vec_t'{"mask_rd",     1'b0, 6'h03, 32'h0,         1'b1, 32'h0000_000F});
    vecs.push_back(vec_t'{"mask_clr",    1'b1, 6'h03, 32'h0,         1'b0, 32'h0});
    vecs.push_back(vec_t'{"ctrl_wr",     1'b1, 6'h01, 32'hFFFF_FFFD, 1'b0, 32'h0});
    vecs.push_back(vec_t'{"ctrl_rd",     1'b0, 6'h01, 32'h0,         1'b1, 32'h0000_0001});
    vecs.push_back(vec_t'{"ctrl_clr",    1'b1, 6'h01, 32'h0,         1'b0, 32'h0});
    vecs.push_back(vec_t'{"ctrl_rd0",    1'b0, 6'h01, 32'h0,         1'b1, 32'h0});
    vecs.push_back(vec_t'{"txdata_rd",   1'b0, 6'h04, 32'h0,         1'b1, 32'h0});
    vecs.push_back(vec_t'{"rxdata_mt",   1'b0, 6'h05, 32'h0,         1'b1, 32'h0});
    vecs.push_back(vec_t'{"stat_rst",    1'b0, 6'h02, 32'h0,         1'b1, 32'h0});

    // Reset values while reset is held
    #2;
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_irq", {31'h0, bus.irq}, 32'h0);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    @(posedge sys_clk);
    @(posedge sys_clk);
    #3 sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // Register map vectors
    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].chk) check(vecs[i].name, bus.readdata, vecs[i].exp);
    end

    // TX fill to 16, then an overflowing write
    for (int i = 0; i < 16; i++) step(1'b1, 6'h04, 32'h100 + i);
    step(1'b1, 6'h04, 32'h110);
    rd("tx_full_stat", 6'h07, 32'h0009_0010);
    rd("tx_ovf_stat", 6'h02, 32'h0000_0002);
    check("tx_valid_full", {31'h0, tx_valid}, 32'h1);
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("tx_drain_data", tx_data, 32'h100 + i);
      step(1'b0, 6'h00, 32'h0);
    end
    tx_ready = 1'b0;
    check("tx_valid_drained", {31'h0, tx_valid}, 32'h0);
    rd("tx_drained_stat", 6'h02, 32'h0000_000A);
    step(1'b1, 6'h02, 32'hF);
    rd("stat_w1c_all", 6'h02, 32'h0);

    // RX push raises irq two cycles later
    step(1'b1, 6'h01, 32'h1);
    step(1'b1, 6'h03, 32'h1);
    rx_valid = 1'b1;
    rx_data = 32'hA5A5_0001;
    step(1'b0, 6'h00, 32'h0);
    rx_valid = 1'b0;
    check("irq_after_1", {31'h0, bus.irq}, 32'h0);
    step(1'b0, 6'h00, 32'h0);
    check("irq_after_2", {31'h0, bus.irq}, 32'h1);
    rd("rx_head", 6'h05, 32'hA5A5_0001);
    step(1'b1, 6'h06, 32'h0);
    step(1'b1, 6'h02, 32'h1);
    check("irq_w1c_1", {31'h0, bus.irq}, 32'h1);
    step(1'b0, 6'h00, 32'h0);
    check("irq_w1c_2", {31'h0, bus.irq}, 32'h0);
    rd("rx_empty_stat", 6'h07, 32'h000A_0000);

    // RX underflow, then RX_NE set racing a W1C of the same bit
    step(1'b1, 6'h06, 32'h0);
    rd("rx_unf_stat", 6'h02, 32'h0000_0004);
    rd("rx_unf_fstat", 6'h07, 32'h000A_0000);
    step(1'b1, 6'h02, 32'h4);
    rx_valid = 1'b1;
    rx_data = 32'h0000_BEEF;
    step(1'b1, 6'h02, 32'h1);
    rx_valid = 1'b0;
    rd("set_wins_w1c", 6'h02, 32'h0000_0001);
    step(1'b1, 6'h06, 32'h0);
    step(1'b1, 6'h02, 32'h1);
    step(1'b1, 6'h01, 32'h0);
    step(1'b1, 6'h03, 32'h0);
    rd("stat_clean", 6'h02, 32'h0);

    // Flush with 8 TX words queued
    for (int i = 0; i < 8; i++) step(1'b1, 6'h04, 32'h200 + i);
    rd("tx8_fstat", 6'h07, 32'h0008_0008);
    step(1'b1, 6'h01, 32'h2);
    check("flush_tx_valid", {31'h0, tx_valid}, 32'h0);
    rd("flush_fstat", 6'h07, 32'h000A_0000);
    rd("flush_ctrl", 6'h01, 32'h0);
    rd("flush_scratch", 6'h08, 32'h5555_5555);
    rd("flush_stat", 6'h02, 32'h0);

    // Continuous push+pop at count 15 for 40 cycles
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 6'h04, 32'h300 + i);
      q.push_back(32'h300 + i);
    end
    tx_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      check("stream_head", tx_data, q[0]);
      step(1'b1, 6'h04, 32'h400 + k);
      void'(q.pop_front());
      q.push_back(32'h400 + k);
    end
    tx_ready = 1'b0;
    rd("stream_fstat", 6'h07, 32'h0008_000F);
    rd("stream_no_ovf", 6'h02, 32'h0);
    tx_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      check("stream_drain", tx_data, q[0]);
      step(1'b0, 6'h00, 32'h0);
      void'(q.pop_front());
    end
    tx_ready = 1'b0;
    check("stream_empty", {31'h0, tx_valid}, 32'h0);
    rd("stream_drained", 6'h02, 32'h0000_0008);

    // Reset asserted mid-traffic
    step(1'b1, 6'h04, 32'h55);
    rx_valid = 1'b1;
    rx_data = 32'h1;
    step(1'b0, 6'h00, 32'h0);
    rx_valid = 1'b0;
    #2 sys_rst_n = 1'b0;
    #1;
    check("mid_rst_readdata", bus.readdata, 32'h0);
    check("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("mid_rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    #2 sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    rd("post_rst_scratch", 6'h08, 32'h0);
    rd("post_rst_fstat", 6'h07, 32'h000A_0000);
    rd("post_rst_stat", 6'h02, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dgio_mbox.md
# dgio_mbox

Register-mapped mailbox that sits directly behind the dgio PIM bridge and consumes its simple word bus (write, writedata, address) and returns readdata and irq. It provides the host with an ID, a control register, a scratch register, masked write-1-to-clear interrupts, and two FIFOs. The TX FIFO carries host writes to a user-side valid/ready stream. The RX FIFO carries a user-side stream back to the host.

## Interface
- C_ID, 32'h4447_0100, constant returned at word 0x00
- C_FIFO_AW, 4, log2 of each FIFO depth (16 words); legal range 1..7
- sys_clk  in  1  single clock; all logic rising-edge
- sys_rst_n  in  1  reset, asynchronous assert, active-low
- write  in  1  write strobe, one word per high cycle
- writedata  in  32  write data
- address  in  6  word address, used for both reads and writes
- readdata  out  32  registered read data
- irq  out  1  registered level interrupt
- tx_data  out  32  TX FIFO head word
- tx_valid  out  1  TX FIFO not empty
- tx_ready  in  1  user accepts tx_data when tx_valid & tx_ready
- rx_data  in  32  user word to host
- rx_valid  in  1  user offers rx_data
- rx_ready  out  1  RX FIFO not full; push when rx_valid & rx_ready

## Operation
- Register map (word address):
  - 0x00 ID: read-only, returns C_ID.
  - 0x01 CTRL: [0] irq_en is RW. [1] flush is write-only and self-clearing: writing 1 empties both FIFOs next cycle; reads 0.
  - 0x02 IRQ_STAT: write-1-to-clear. [0] RX_NE, [1] TX_OVF, [2] RX_UNF, [3] TX_DRAINED.
  - 0x03 IRQ_MASK: [3:0] RW.
  - 0x04 TX_DATA: a write pushes writedata into the TX FIFO; reads return 0.
  - 0x05 RX_DATA: read-only, returns the RX FIFO head, or 0 when empty.
  - 0x06 RX_POP: any write pops one RX word.
  - 0x07 FIFO_STAT: read-only. [7:0] tx count, [15:8] rx count, [16] tx_full, [17] tx_empty, [18] rx_full, [19] rx_empty.
  - 0x08 SCRATCH: RW 32 bits.
  - Other addresses: reads return 0; writes are ignored.
- Unused register bits read 0.
- IRQ_STAT set conditions:
  - RX_NE: a push into an empty RX FIFO.
  - TX_OVF: a TX_DATA write while the TX FIFO is full. The word is dropped.
  - RX_UNF: an RX_POP write while the RX FIFO is empty. The pop is ignored.
  - TX_DRAINED: a pop leaves the TX FIFO empty, and no push happens in the same cycle.
- A set event and a W1C of the same bit in the same cycle: the set wins.
- irq is registered as CTRL[0] & |(IRQ_STAT & IRQ_MASK).
- FIFOs:
  - Circular buffers with C_FIFO_AW-bit pointers that wrap modulo depth, plus a count of C_FIFO_AW+1 bits.
  - Head is show-ahead: tx_data always presents the head word.
  - Simultaneous push and pop: both take effect and the count is unchanged.
  - TX full check uses pre-pop state. A TX_DATA write to a full FIFO is dropped and flagged, even if tx_ready pops in the same cycle.
  - Flush and a push in the same cycle: flush wins and the push is discarded. No IRQ flags are set by a discarded push.
  - Flush does not alter IRQ_STAT, CTRL[0], MASK or SCRATCH.

## Timing
- Reset values:
  - readdata=0, irq=0, tx_valid=0, rx_ready=1.
  - CTRL, IRQ_STAT, IRQ_MASK and SCRATCH are 0. Both FIFOs are empty.
  - tx_data is undefined while tx_valid=0.
- Read latency is 1 cycle. readdata in cycle n+1 reflects address and register state at the cycle-n edge, before any cycle-n write takes effect. Reads have no side effects.
- Write effects are visible to the readdata sample and the stream ports on the following cycle.
- tx_valid and rx_ready are driven from registered state and have no combinational path from tx_ready or rx_valid.
- irq asserts 2 cycles after the triggering event: stat bit set at edge n+1, irq at edge n+2. It drops 2 cycles after the clearing W1C write.
- Reset assertion mid-transfer returns everything to reset values immediately. No partial word survives.

## Test plan
- Reset, then read 0x00, 0x07, 0x3F -> 32'h4447_0100; 32'h000A_0000 (both empty, counts 0); 0.
- Write 16 words 0x100..0x10F to 0x04 with tx_ready=0, then one more (0x110). -> FIFO_STAT tx count=16, tx_full=1; IRQ_STAT=0x2; 0x110 absent. Then tx_ready=1 -> 0x100..0x10F in order, TX_DRAINED set.
- Set CTRL=1 and MASK=0x1, push rx_data 0xA5A5_0001 -> irq high 2 cycles after the push. Read 0x05 -> 0xA5A5_0001. Write 0x06 then W1C 0x1 -> irq low, rx_empty=1.
- Write 0x06 with the RX FIFO empty -> RX_UNF=1, rx count stays 0. Same cycle as an RX_NE set plus W1C of bit 0 -> bit 0 ends at 1.
- With TX count=8, write CTRL=0x2 with tx_ready=0 -> next cycle tx_valid=0, count 0, CTRL reads 0, SCRATCH preserved.
- Continuous TX push and pop every cycle for 40 cycles at count 15 -> no overflow, count constant, pointers wrap, data order preserved.
